// File: rtl/instr_loader.sv
`default_nettype none
// =============================================================================
// instr_loader: parses a length/data/checksum byte stream and writes the
// resulting instruction words to instruction memory, holding the core meanwhile.
// Revision: 1.0
// =============================================================================
module instr_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned WIDX_W = $clog2(DEPTH_WORDS + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [WIDX_W-1:0] widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [7:0]        csum_q, csum_d;
    logic [31:0]       word_q, word_d;

    logic              byte_ready_q;
    logic              imem_we_q;
    logic [31:0]       imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic              core_hold_q;
    logic              done_q;
    logic              err_q;

    logic              w_xfer;
    logic [15:0]       w_len_rx;
    logic [31:0]       w_widx_next;

    assign w_xfer      = byte_valid & byte_ready_q;
    assign w_len_rx    = {byte_data, len_q[7:0]};
    assign w_widx_next = 32'(widx_q) + 32'd1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        csum_d  = csum_q;
        word_d  = word_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    csum_d  = '0;
                end
            end
            LEN0: begin
                if (w_xfer) begin
                    len_d[7:0] = byte_data;
                    state_d    = LEN1;
                end
            end
            LEN1: begin
                if (w_xfer) begin
                    len_d[15:8] = byte_data;
                    if ((w_len_rx == 16'd0) || (32'(w_len_rx) > DEPTH_WORDS)) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
                    word_d[{bidx_q, 3'b000} +: 8] = byte_data;
                    csum_d = csum_q ^ byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                widx_d  = widx_q + 1'b1;
                state_d = (w_widx_next == 32'(len_q)) ? CSUM : DATA;
            end
            CSUM: begin
                if (w_xfer) begin
                    state_d = (byte_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            widx_q       <= '0;
            bidx_q       <= '0;
            csum_q       <= '0;
            word_q       <= '0;
            byte_ready_q <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            core_hold_q  <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            widx_q       <= widx_d;
            bidx_q       <= bidx_d;
            csum_q       <= csum_d;
            word_q       <= word_d;
            byte_ready_q <= (state_d == LEN0) || (state_d == LEN1) ||
                            (state_d == DATA) || (state_d == CSUM);
            imem_we_q    <= (state_d == WRITE);
            if (state_d == WRITE) begin
                imem_addr_q  <= BASE_ADDR + (32'(widx_q) << 2);
                imem_wdata_q <= word_d;
            end
            core_hold_q  <= (state_d != DONE);
            done_q       <= (state_d == DONE);
            err_q        <= (state_d == ERR);
        end
    end

    assign byte_ready = byte_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_hold  = core_hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// =============================================================================
// tb_instr_loader: directed streams with a write/status scoreboard.
// Revision: 1.0
// =============================================================================
module tb_instr_loader;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;

    instr_loader #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [2:0] exp_st[$];   // {done, err, core_hold}
    logic [7:0] stream[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes and terminal status as the DUT presents them
    initial begin
        wr_t        e;
        logic [2:0] s;
        bit         prev_term;
        prev_term = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (imem_we) begin
                    if (exp_wr.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_write: got addr %h data %h, expected none",
                                 imem_addr, imem_wdata);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", imem_addr, e.addr);
                        chk("wr_data", imem_wdata, e.data);
                    end
                    chk("ready_in_write", 32'(byte_ready), 32'd0);
                end
                if ((done || err) && !prev_term) begin
                    if (exp_st.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_status: got done=%b err=%b, expected none", done, err);
                    end else begin
                        s = exp_st.pop_front();
                        chk("status", 32'({done, err, core_hold}), 32'(s));
                    end
                end
                prev_term = done || err;
            end else begin
                prev_term = 1'b0;
            end
        end
    end

    task automatic push_len(input logic [15:0] n);
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        stream.push_back(w[7:0]);
        stream.push_back(w[15:8]);
        stream.push_back(w[23:16]);
        stream.push_back(w[31:24]);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_stream(input bit jitter, input bit start_noise);
        int budget;
        bit sent;
        for (int i = 0; i < stream.size(); i++) begin
            sent   = 1'b0;
            budget = 200;
            while (!sent) begin
                @(negedge clk);
                if (budget == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL byte_timeout: byte %0d not accepted, expected accept within 200 cycles", i);
                    byte_valid = 1'b0;
                    start      = 1'b0;
                    stream.delete();
                    return;
                end
                byte_data  = stream[i];
                byte_valid = jitter ? ($urandom_range(0, 1) == 1) : 1'b1;
                start      = start_noise && (i < stream.size() - 1);
                sent       = byte_valid && byte_ready;
                budget--;
            end
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start      = 1'b0;
        stream.delete();
    endtask

    task automatic wait_term();
        int c;
        c = 0;
        while (!(done || err) && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c == 100) begin
            n_vec++;
            n_err++;
            $display("FAIL term_timeout: got done=0 err=0, expected done or err within 100 cycles");
        end
    endtask

    task automatic load_two(input logic [7:0] csum, input bit jitter);
        exp_wr.push_back({BASE, 32'h0050_0093});
        exp_wr.push_back({BASE + 32'd4, 32'h00A0_0113});
        push_len(16'd2);
        push_word(32'h0050_0093);
        push_word(32'h00A0_0113);
        stream.push_back(csum);
        do_start();
        send_stream(jitter, 1'b0);
        wait_term();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(byte_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);
        chk("idle_hold", 32'(core_hold), 32'd1);

        // N=1, single word 0x13, checksum 0x13
        exp_wr.push_back({BASE, 32'h0000_0013});
        exp_st.push_back(3'b100);
        stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        do_start();
        send_stream(1'b0, 1'b0);
        wait_term();
        chk("n1_done", 32'(done), 32'd1);
        chk("n1_hold", 32'(core_hold), 32'd0);

        // N=2, checksum 93^50^13^01^A0 = 71
        exp_st.push_back(3'b100);
        load_two(8'h71, 1'b0);
        chk("n2_done", 32'(done), 32'd1);

        // Bad checksum
        exp_st.push_back(3'b011);
        load_two(8'h70, 1'b0);
        chk("badcs_err", 32'(err), 32'd1);
        chk("badcs_done", 32'(done), 32'd0);
        chk("badcs_hold", 32'(core_hold), 32'd1);

        // Zero length: error right after LEN_HI
        exp_st.push_back(3'b011);
        push_len(16'd0);
        do_start();
        send_stream(1'b0, 1'b0);
        chk("len0_err", 32'(err), 32'd1);

        // Length above depth
        exp_st.push_back(3'b011);
        push_len(16'(DEPTH + 1));
        do_start();
        send_stream(1'b0, 1'b0);
        chk("lenbig_err", 32'(err), 32'd1);

        // Exactly DEPTH words, start toggled mid-load; bytes cancel so csum 00
        exp_wr.push_back({BASE,          32'h1111_1111});
        exp_wr.push_back({BASE + 32'd4,  32'h2222_2222});
        exp_wr.push_back({BASE + 32'd8,  32'h3333_3333});
        exp_wr.push_back({BASE + 32'd12, 32'h4444_4444});
        exp_st.push_back(3'b100);
        push_len(16'(DEPTH));
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        push_word(32'h4444_4444);
        stream.push_back(8'h00);
        do_start();
        send_stream(1'b0, 1'b1);
        wait_term();
        chk("full_done", 32'(done), 32'd1);

        // Random byte_valid gaps
        exp_st.push_back(3'b100);
        load_two(8'h71, 1'b1);
        chk("jitter_done", 32'(done), 32'd1);

        // Reset after 6 data bytes: only the first word lands
        exp_wr.push_back({BASE, 32'h0050_0093});
        push_len(16'd2);
        push_word(32'h0050_0093);
        stream.push_back(8'h13);
        stream.push_back(8'h01);
        do_start();
        send_stream(1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_hold", 32'(core_hold), 32'd1);
        chk("midrst_ready", 32'(byte_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst        = 1'b1;
        byte_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("postrst_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;
        exp_st.push_back(3'b100);
        load_two(8'h71, 1'b0);
        chk("reload_done", 32'(done), 32'd1);

        repeat (5) @(negedge clk);
        chk("wr_queue_left", 32'(exp_wr.size()), 32'd0);
        chk("st_queue_left", 32'(exp_st.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of instruction word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, meaning the maximum number of words the loader accepts.
REQ-003 SHALL have one clock and reset is asynchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-005 start  input  1  request to begin a load, sampled each cycle.
REQ-006 byte_valid  input  1  byte_data holds a valid byte.
REQ-007 byte_data  input  8  byte of the incoming load stream.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe.
REQ-010 imem_addr  output  32  instruction-memory byte address, word-aligned.
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 core_hold  output  1  active-high, holds the core in reset.
REQ-013 done  output  1  load completed with a good checksum.
REQ-014 err  output  1  load aborted: bad length or bad checksum.

Function
REQ-015 SHALL treat a byte as transferred only in a cycle where byte_valid=1 and byte_ready=1.
REQ-016 SHALL parse the stream as: LEN_LO, LEN_HI (N, 16-bit little-endian), then N*4 data bytes (each word little-endian), then one CSUM byte.
REQ-017 SHALL use the FSM states IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR.
REQ-018 IDLE: start=1 -> LEN0; clear the word index, byte index and checksum accumulator.
REQ-019 LEN0 -> LEN1 on a transfer, capturing N[7:0]; LEN1 on a transfer captures N[15:8].
REQ-020 LEN1 transfer with N=0 or N>DEPTH_WORDS -> ERR; otherwise -> DATA.
REQ-021 DATA: each transfer shifts the byte into lane byte_idx of the word buffer and XORs it into the accumulator; the 4th byte -> WRITE.
REQ-022 WRITE, exactly one cycle: imem_we=1, imem_addr=BASE_ADDR+4*word_idx, imem_wdata=the assembled word; then word_idx+1; -> CSUM if word_idx+1==N, else DATA.
REQ-023 CSUM transfer: byte equal to accumulator -> DONE, otherwise -> ERR.
REQ-024 byte_ready=1 only in LEN0, LEN1, DATA and CSUM.
REQ-025 imem_we=1 only in WRITE; imem_addr and imem_wdata are don't-care but stable when imem_we=0.
REQ-026 core_hold=1 in every state except DONE; done=1 only in DONE; err=1 only in ERR.
REQ-027 DONE or ERR with start=1 -> LEN0 (reload); core_hold reasserts in that same cycle's next state.
REQ-028 start SHALL be ignored in LEN0..CSUM.
REQ-029 Address arithmetic SHALL be 32-bit and wrap modulo 2^32; word_idx width SHALL be clog2(DEPTH_WORDS+1).
REQ-030 Words already written before an abort or reset SHALL NOT be rewritten or cleared.

Reset
REQ-031 rst=0 SHALL asynchronously force IDLE, core_hold=1, done=0, err=0, imem_we=0, byte_ready=0, and clear all counters and the accumulator.
REQ-032 Reset mid-load SHALL abandon the load; the next load requires start after rst returns to 1.

Verification
REQ-033 N=1, bytes 01 00 13 00 00 00 13 -> a single WRITE with addr=BASE_ADDR, wdata=32'h0000_0013; done=1, core_hold=0.
REQ-034 N=2, data words 32'h00500093, 32'h00A00113, correct CSUM -> writes to BASE and BASE+4 in order; done=1.
REQ-035 Same stream as REQ-034 with CSUM xor 8'h01 -> both words written, then err=1, done=0, core_hold=1.
REQ-036 LEN 00 00, and separately N=DEPTH_WORDS+1 -> ERR right after LEN_HI with no imem_we pulse.
REQ-037 byte_valid toggled randomly during the load of REQ-034 -> identical writes, byte_ready=0 throughout WRITE.
REQ-038 rst pulsed low after 6 data bytes -> IDLE at once, core_hold=1; a fresh start plus full stream -> done=1.
